// File: rtl/fifo_pkg.sv
// fifo_pkg: shared definitions for the byte FIFO drain path.
//   DEF_DATA_W  - default byte width
//   FRAME_CNT_W - width of the completed-frame counter
//   occ_e       - skid buffer occupancy encoding (value equals entry count)
//   idx_width() - width of an index that counts 0..n-1 (never below 1)
package fifo_pkg;

  localparam int DEF_DATA_W  = 8;
  localparam int FRAME_CNT_W = 8;

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_TWO   = 2'd2
  } occ_e;

  function automatic int idx_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/fifo_stream_reader_if.sv
// fifo_stream_reader_if: valid/ready byte stream with frame delimiter.
//   m_valid - byte available (driven by master)
//   m_ready - consumer accepts the byte (driven by slave)
//   m_data  - stream byte (driven by master)
//   m_last  - final byte of the current frame (driven by master)
interface fifo_stream_reader_if
  import fifo_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) ();

  logic              m_valid;
  logic              m_ready;
  logic [DATA_W-1:0] m_data;
  logic              m_last;

  modport master (output m_valid, output m_data, output m_last, input m_ready);
  modport slave  (input m_valid, input m_data, input m_last, output m_ready);

endinterface

// File: rtl/skid_buffer_2.sv
// skid_buffer_2: 2-entry register file with 1-bit head/tail pointers and an
// occupancy FSM.
//   clk, rst - clock, synchronous active-high reset (also clears the data)
//   clr      - synchronous clear of occupancy and pointers (data kept)
//   wr       - write wr_data at the tail (ignored when full)
//   rd       - retire the head entry (ignored when empty)
//   rd_data  - head entry
//   valid    - at least one entry held
//   occ      - occupancy state
//
// state     | meaning
// OCC_EMPTY | no entries held
// OCC_ONE   | one entry, at rd_ptr
// OCC_TWO   | both entries held, head at rd_ptr
module skid_buffer_2
  import fifo_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              wr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd,
  output logic [DATA_W-1:0] rd_data,
  output logic              valid,
  output occ_e              occ
);

  occ_e              state;
  logic              wr_ptr;
  logic              rd_ptr;
  logic [DATA_W-1:0] mem [2];
  logic              do_wr;
  logic              do_rd;

  assign do_rd = rd && (state != OCC_EMPTY);
  assign do_wr = wr && (state != OCC_TWO);

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= OCC_EMPTY;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      mem[0] <= '0;
      mem[1] <= '0;
    end else if (clr) begin
      state  <= OCC_EMPTY;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
    end else begin
      if (do_wr) begin
        mem[wr_ptr] <= wr_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (do_rd) begin
        rd_ptr <= ~rd_ptr;
      end
      case (state)
        OCC_EMPTY: if (do_wr) state <= OCC_ONE;
        OCC_ONE: begin
          if (do_wr && !do_rd)      state <= OCC_TWO;
          else if (!do_wr && do_rd) state <= OCC_EMPTY;
        end
        OCC_TWO:   if (do_rd) state <= OCC_ONE;
        default:   state <= OCC_EMPTY;
      endcase
    end
  end

  // The head entry is never the write target while valid, so rd_data holds
  // steady until it is retired.
  assign rd_data = mem[rd_ptr];
  assign valid   = (state != OCC_EMPTY);
  assign occ     = state;

endmodule

// File: rtl/fifo_stream_reader.sv
// fifo_stream_reader: drains a synchronous FIFO (registered read data) onto a
// framed valid/ready stream, one byte per clock when the consumer is ready.
//   clk, rst   - clock, synchronous active-high reset
//   flush      - drop buffered/in-flight bytes, restart frame index
//   fifo_empty - FIFO empty flag
//   fifo_rd_en - pop request to the FIFO
//   fifo_data  - FIFO read data, valid the cycle after a pop
//   m          - stream master port (m_valid/m_ready/m_data/m_last)
//   frame_cnt  - completed frames, modulo 256
module fifo_stream_reader
  import fifo_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int FRAME_LEN = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   fifo_empty,
  output logic                   fifo_rd_en,
  input  logic [DATA_W-1:0]      fifo_data,
  fifo_stream_reader_if.master   m,
  output logic [FRAME_CNT_W-1:0] frame_cnt
);

  localparam int             IDX_W    = idx_width(FRAME_LEN);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);

  logic              inflight;
  logic [IDX_W-1:0]  idx;
  occ_e              occ;
  logic              sb_valid;
  logic [DATA_W-1:0] sb_data;
  logic              pop;
  logic [1:0]        credit_used;

  assign pop = sb_valid && m.m_ready;

  // occ + inflight never exceeds 2 (no pop is issued once two are committed).
  assign credit_used = occ + {1'b0, inflight};

  // A pop retiring the head this cycle frees a slot for a new FIFO read, which
  // keeps one byte per clock flowing with m_ready held high. pop is built from
  // registered m_valid and the consumer's m_ready only.
  assign fifo_rd_en = !fifo_empty && !flush && !rst &&
                      ((credit_used < 2'd2) || (pop && (credit_used == 2'd2)));

  always_ff @(posedge clk) begin
    if (rst) begin
      inflight  <= 1'b0;
      idx       <= '0;
      frame_cnt <= '0;
    end else if (flush) begin
      inflight  <= 1'b0;
      idx       <= '0;
    end else begin
      inflight <= fifo_rd_en;
      if (pop) begin
        if (idx == LAST_IDX) begin
          idx       <= '0;
          frame_cnt <= frame_cnt + 1'b1;
        end else begin
          idx <= idx + 1'b1;
        end
      end
    end
  end

  skid_buffer_2 #(
    .DATA_W (DATA_W)
  ) u_skid (
    .clk     (clk),
    .rst     (rst),
    .clr     (flush),
    .wr      (inflight),
    .wr_data (fifo_data),
    .rd      (pop),
    .rd_data (sb_data),
    .valid   (sb_valid),
    .occ     (occ)
  );

  assign m.m_valid = sb_valid;
  assign m.m_data  = sb_data;
  assign m.m_last  = sb_valid && (idx == LAST_IDX);

endmodule

// File: tb/tb_fifo_stream_reader.sv
module tb_fifo_stream_reader;
  import fifo_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic flush0;
  logic flush1;

  int n_chk  = 0;
  int n_fail = 0;

  // DUT0: FRAME_LEN = 4, fed from a queue-like FIFO model
  logic       fifo_empty0;
  logic       fifo_rd_en0;
  logic [7:0] fifo_data0 = 8'h00;
  logic [7:0] frame_cnt0;
  logic [7:0] fifo_mem [256];
  int         wr_cnt = 0;
  int         rd_cnt = 0;

  fifo_stream_reader_if #(.DATA_W(8)) s0 ();

  fifo_stream_reader #(.DATA_W(8), .FRAME_LEN(4)) dut0 (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush0),
    .fifo_empty (fifo_empty0),
    .fifo_rd_en (fifo_rd_en0),
    .fifo_data  (fifo_data0),
    .m          (s0.master),
    .frame_cnt  (frame_cnt0)
  );

  assign fifo_empty0 = (wr_cnt == rd_cnt);

  always @(posedge clk) begin
    if (fifo_rd_en0) begin
      fifo_data0 <= fifo_mem[rd_cnt[7:0]];
      rd_cnt     <= rd_cnt + 1;
    end
  end

  // DUT1: FRAME_LEN = 1, fed from an endless counting source
  logic       feed1 = 1'b0;
  logic       fifo_empty1;
  logic       fifo_rd_en1;
  logic [7:0] fifo_data1 = 8'h00;
  logic [7:0] frame_cnt1;
  int         cnt1 = 0;

  fifo_stream_reader_if #(.DATA_W(8)) s1 ();

  fifo_stream_reader #(.DATA_W(8), .FRAME_LEN(1)) dut1 (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush1),
    .fifo_empty (fifo_empty1),
    .fifo_rd_en (fifo_rd_en1),
    .fifo_data  (fifo_data1),
    .m          (s1.master),
    .frame_cnt  (frame_cnt1)
  );

  assign fifo_empty1 = !feed1;

  always @(posedge clk) begin
    if (fifo_rd_en1) begin
      fifo_data1 <= cnt1[7:0];
      cnt1       <= cnt1 + 1;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int n, input logic [7:0] base);
    for (int i = 0; i < n; i++) begin
      fifo_mem[8'(wr_cnt + i)] = base + 8'(i);
    end
    wr_cnt = wr_cnt + n;
  endtask

  typedef struct {
    int         push_n;
    logic [7:0] base;
    logic       ready;
    logic       e_rd;
    logic       e_v;
    logic [7:0] e_d;
    logic       e_l;
    logic [7:0] e_fc;
  } vec_t;

  vec_t vec [11];

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached before end of test");
    $fatal(1, "timeout");
  end

  initial begin
    int pulses;
    int got;

    // basic stream, one row per cycle starting with the cycle fifo_empty falls
    vec[0]  = '{8, 8'h11, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 8'd0};
    vec[1]  = '{0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 8'd0};
    vec[2]  = '{0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h11, 1'b0, 8'd0};
    vec[3]  = '{0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h12, 1'b0, 8'd0};
    vec[4]  = '{0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h13, 1'b0, 8'd0};
    vec[5]  = '{0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h14, 1'b1, 8'd0};
    vec[6]  = '{0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h15, 1'b0, 8'd1};
    vec[7]  = '{0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h16, 1'b0, 8'd1};
    vec[8]  = '{0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h17, 1'b0, 8'd1};
    vec[9]  = '{0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h18, 1'b1, 8'd1};
    vec[10] = '{0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 8'd2};

    rst = 1'b1;
    flush0 = 1'b0;
    flush1 = 1'b0;
    s0.m_ready = 1'b0;
    s1.m_ready = 1'b0;
    next_cycle();
    next_cycle();
    #1;
    chk("reset_rd_en", fifo_rd_en0, 0);
    chk("reset_valid", s0.m_valid, 0);
    chk("reset_data", s0.m_data, 0);
    chk("reset_last", s0.m_last, 0);
    chk("reset_frame_cnt", frame_cnt0, 0);
    chk("reset_valid_fl1", s1.m_valid, 0);
    chk("reset_frame_cnt_fl1", frame_cnt1, 0);
    next_cycle();
    rst = 1'b0;

    // basic stream
    for (int i = 0; i < 11; i++) begin
      next_cycle();
      s0.m_ready = vec[i].ready;
      if (vec[i].push_n > 0) push(vec[i].push_n, vec[i].base);
      #1;
      chk($sformatf("basic[%0d].rd_en", i), fifo_rd_en0, vec[i].e_rd);
      chk($sformatf("basic[%0d].valid", i), s0.m_valid, vec[i].e_v);
      if (vec[i].e_v) chk($sformatf("basic[%0d].data", i), s0.m_data, vec[i].e_d);
      chk($sformatf("basic[%0d].last", i), s0.m_last, vec[i].e_l);
      chk($sformatf("basic[%0d].frame_cnt", i), frame_cnt0, vec[i].e_fc);
    end

    // backpressure: exactly two pops outstanding, head held stable
    next_cycle();
    s0.m_ready = 1'b0;
    push(8, 8'h11);
    #1;
    pulses = fifo_rd_en0 ? 1 : 0;
    for (int i = 0; i < 7; i++) begin
      next_cycle();
      #1;
      if (fifo_rd_en0) pulses++;
      if (i >= 1) begin
        chk($sformatf("bp_hold_valid[%0d]", i), s0.m_valid, 1);
        chk($sformatf("bp_hold_data[%0d]", i), s0.m_data, 8'h11);
      end
    end
    chk("bp_rd_pulses", pulses, 2);
    got = 0;
    for (int i = 0; i < 20 && got < 8; i++) begin
      next_cycle();
      s0.m_ready = 1'b1;
      #1;
      if (s0.m_valid) begin
        chk($sformatf("bp_data[%0d]", got), s0.m_data, 32'h11 + got);
        got++;
      end
    end
    chk("bp_count", got, 8);
    next_cycle();
    #1;
    chk("bp_no_dup", s0.m_valid, 0);
    chk("bp_frame_cnt", frame_cnt0, 4);

    // toggling ready over 10 bytes
    next_cycle();
    s0.m_ready = 1'b0;
    push(10, 8'h30);
    got = 0;
    for (int i = 0; i < 60 && got < 10; i++) begin
      next_cycle();
      s0.m_ready = (i[0] == 1'b0);
      #1;
      if (s0.m_valid && s0.m_ready) begin
        chk($sformatf("tog_data[%0d]", got), s0.m_data, 32'h30 + got);
        chk($sformatf("tog_last[%0d]", got), s0.m_last, (got == 3 || got == 7) ? 1 : 0);
        got++;
      end
    end
    chk("tog_count", got, 10);
    next_cycle();
    s0.m_ready = 1'b0;
    #1;
    chk("tog_frame_cnt", frame_cnt0, 6);

    // idle flush to restart the partial frame left by the toggle test
    next_cycle();
    flush0 = 1'b1;
    next_cycle();
    flush0 = 1'b0;
    #1;
    chk("idle_flush_frame_cnt", frame_cnt0, 6);

    // flush mid-frame with two bytes accepted and the skid buffer full
    next_cycle();
    push(5, 8'h50);
    #1;
    chk("fl_first_rd", fifo_rd_en0, 1);
    next_cycle();
    next_cycle();
    next_cycle();
    s0.m_ready = 1'b1;
    #1;
    chk("fl_head0", s0.m_data, 8'h50);
    next_cycle();
    #1;
    chk("fl_head1", s0.m_data, 8'h51);
    next_cycle();
    s0.m_ready = 1'b0;
    #1;
    chk("fl_head2", s0.m_data, 8'h52);
    chk("fl_no_rd_when_full", fifo_rd_en0, 0);
    next_cycle();
    s0.m_ready = 1'b1;
    flush0 = 1'b1;
    #1;
    chk("fl_valid_before", s0.m_valid, 1);
    chk("fl_rd_gated", fifo_rd_en0, 0);
    wr_cnt = rd_cnt;
    next_cycle();
    flush0 = 1'b0;
    #1;
    chk("fl_valid_after", s0.m_valid, 0);
    chk("fl_frame_cnt_kept", frame_cnt0, 6);
    next_cycle();
    push(4, 8'hA0);
    got = 0;
    for (int i = 0; i < 20 && got < 4; i++) begin
      next_cycle();
      #1;
      if (s0.m_valid) begin
        chk($sformatf("fl_data[%0d]", got), s0.m_data, 32'hA0 + got);
        chk($sformatf("fl_last[%0d]", got), s0.m_last, (got == 3) ? 1 : 0);
        got++;
      end
    end
    chk("fl_count", got, 4);
    next_cycle();
    #1;
    chk("fl_frame_cnt_after", frame_cnt0, 7);

    // reset with one byte buffered and one in flight
    next_cycle();
    s0.m_ready = 1'b0;
    push(3, 8'hC0);
    next_cycle();
    next_cycle();
    rst = 1'b1;
    s0.m_ready = 1'b1;
    #1;
    chk("rst_mid_valid_before", s0.m_valid, 1);
    chk("rst_mid_rd_gated", fifo_rd_en0, 0);
    wr_cnt = rd_cnt;
    next_cycle();
    rst = 1'b0;
    #1;
    chk("rst_mid_rd_en", fifo_rd_en0, 0);
    chk("rst_mid_valid", s0.m_valid, 0);
    chk("rst_mid_data", s0.m_data, 0);
    chk("rst_mid_last", s0.m_last, 0);
    chk("rst_mid_frame_cnt", frame_cnt0, 0);
    for (int i = 0; i < 4; i++) begin
      next_cycle();
      #1;
      chk($sformatf("rst_no_stray[%0d]", i), s0.m_valid, 0);
    end

    // FRAME_LEN = 1: every byte is last, frame_cnt wraps 255 -> 0 -> 1
    s1.m_ready = 1'b1;
    got = 0;
    for (int i = 0; i < 400 && got < 257; i++) begin
      next_cycle();
      feed1 = (cnt1 < 257);
      #1;
      if (s1.m_valid) begin
        chk($sformatf("fl1_last[%0d]", got), s1.m_last, 1);
        chk($sformatf("fl1_data[%0d]", got), s1.m_data, got & 32'hFF);
        chk($sformatf("fl1_frame_cnt[%0d]", got), frame_cnt1, got & 32'hFF);
        got++;
      end
    end
    chk("fl1_count", got, 257);
    next_cycle();
    feed1 = 1'b0;
    #1;
    chk("fl1_frame_cnt_final", frame_cnt1, 1);
    chk("fl1_valid_final", s1.m_valid, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
